// File: rtl/multicycle_controller.sv
// Moore FSM sequencing a multicycle ARM-style datapath (fetch, decode, memory, ALU, branch).
// Defining MC_BRANCH_LINK_EN adds branch-with-link: BRANCH with Funct[4]=1 also writes PC+4 to LR.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [2:0] Cond,
  input  logic [3:0] ALUFlags,
  output logic [2:0] RegSrc,
  output logic       AdrSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic [1:0] ImmSrc,
  output logic       AluSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ResultSrc,
  output logic [1:0] enhanced_op,
  output logic [3:0] state,
  output logic       undef
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ENH = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;
  localparam logic [2:0] ALU_ENH = 3'b111;

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       undef_q, undef_d;
  logic [1:0] op_q, op_d;
  logic [5:0] funct_q, funct_d;

  logic       is_cmp;
  logic       regwrite_c, memwrite_c, pcwrite_c, irwrite_c;

  // flags are {N,Z,C,V}
  function automatic logic cond_pass(input logic [2:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      3'b000:  return z;
      3'b001:  return !z;
      3'b010:  return c;
      3'b011:  return !c;
      3'b100:  return n;
      3'b101:  return !n;
      3'b110:  return n == v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [2:0] alu_decode(input logic [1:0] op, input logic [3:0] cmd);
    if (op == OP_ENH) return ALU_ENH;
    case (cmd)
      4'b0100:         return ALU_ADD;
      4'b0010, 4'b1010: return ALU_SUB;
      4'b0000:         return ALU_AND;
      4'b1100:         return ALU_ORR;
      4'b0001:         return ALU_EOR;
      default:         return ALU_ADD;
    endcase
  endfunction

  assign is_cmp = (op_q == OP_DP) && (funct_q[4:1] == 4'b1010);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      flags_q <= 4'b0000;
      undef_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      undef_q <= undef_d;
    end
  end

  // Decode latches are only meaningful after DECODE, so they carry no reset.
  always_ff @(posedge clk) begin
    op_q    <= op_d;
    funct_q <= funct_d;
  end

  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    undef_d = 1'b0;
    op_d    = op_q;
    funct_d = funct_q;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        op_d    = Op;
        funct_d = Funct;
        if (!cond_pass(Cond, flags_q)) begin
          state_d = S_FETCH;
        end else begin
          case (Op)
            OP_MEM: state_d = S_MEMADR;
            OP_BR:  state_d = S_BRANCH;
            default: begin
              if ((Op == OP_ENH) && (Funct[5:4] == 2'b11)) begin
                state_d = S_FETCH;
                undef_d = 1'b1;
              end else begin
                state_d = Funct[5] ? S_EXECI : S_EXECR;
              end
            end
          endcase
        end
      end
      S_MEMADR: state_d = funct_q[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = S_FETCH;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      S_ALUWB: begin
        state_d = S_FETCH;
        if (funct_q[0] || is_cmp) flags_d = ALUFlags;
      end
      S_BRANCH: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    RegSrc      = 3'b000;
    AdrSrc      = 1'b0;
    ImmSrc      = 2'b00;
    AluSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUControl  = ALU_ADD;
    ResultSrc   = 2'b00;
    enhanced_op = 2'b00;
    regwrite_c  = 1'b0;
    memwrite_c  = 1'b0;
    pcwrite_c   = 1'b0;
    irwrite_c   = 1'b0;
    case (state_q)
      S_FETCH: begin
        irwrite_c = 1'b1;
        AluSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pcwrite_c = 1'b1;
      end
      S_DECODE: begin
        AluSrcA = 1'b1;
        ALUSrcB = 2'b10;
        RegSrc  = 3'b001;
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        ImmSrc  = 2'b01;
      end
      S_MEMRD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        regwrite_c = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc     = 1'b1;
        memwrite_c = 1'b1;
        RegSrc     = 3'b010;
      end
      // ALU operation is held through ALUWB so ALUFlags stay valid for the flag load.
      S_EXECR, S_EXECI, S_ALUWB: begin
        ALUSrcB    = funct_q[5] ? 2'b01 : 2'b00;
        ALUControl = alu_decode(op_q, funct_q[4:1]);
        if (op_q == OP_ENH) enhanced_op = funct_q[2:1];
        if (state_q == S_ALUWB) regwrite_c = !is_cmp;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ImmSrc    = 2'b10;
        ResultSrc = 2'b10;
        pcwrite_c = 1'b1;
`ifdef MC_BRANCH_LINK_EN
        if (funct_q[4]) begin
          RegSrc[2]  = 1'b1;
          regwrite_c = 1'b1;
        end
`else
`endif
      end
      default: ;
    endcase
  end

  // Enables are gated by reset directly so they drop the instant reset asserts.
  assign RegWrite = regwrite_c & reset;
  assign MemWrite = memwrite_c & reset;
  assign PCWrite  = pcwrite_c  & reset;
  assign IRWrite  = irwrite_c  & reset;
  assign state    = state_q;
  assign undef    = undef_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction state-sequence model plus directed scenarios.
`timescale 1ns/1ps
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'b000000;
  logic [2:0] Cond = 3'b000;
  logic [3:0] ALUFlags = 4'b0000;
  logic [2:0] RegSrc;
  logic       AdrSrc, RegWrite, MemWrite, PCWrite, IRWrite;
  logic [1:0] ImmSrc;
  logic       AluSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] ResultSrc;
  logic [1:0] enhanced_op;
  logic [3:0] state;
  logic       undef;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Cond(Cond), .ALUFlags(ALUFlags),
    .RegSrc(RegSrc), .AdrSrc(AdrSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .ImmSrc(ImmSrc), .AluSrcA(AluSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ResultSrc(ResultSrc),
    .enhanced_op(enhanced_op), .state(state), .undef(undef)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic        chk_en = 1'b0;
  logic [24:0] exp_vec = '0;
  logic [24:0] act_vec;
  logic [3:0]  mflags = 4'b0000;
  logic        und_pend = 1'b0;

  int         log_st[$];
  logic [3:0] log_en[$];
  logic [2:0] log_rs[$];
  logic [1:0] log_res[$];
  logic       log_und[$];

  assign act_vec = {state, RegSrc, AdrSrc, RegWrite, MemWrite, PCWrite, IRWrite, ImmSrc,
                    AluSrcA, ALUSrcB, ALUControl, ResultSrc, enhanced_op, undef};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cycle outputs", 32'(act_vec), 32'(exp_vec));
      log_st.push_back(int'(state));
      log_en.push_back({RegWrite, MemWrite, PCWrite, IRWrite});
      log_rs.push_back(RegSrc);
      log_res.push_back(ResultSrc);
      log_und.push_back(undef);
    end
  end

  task automatic clear_logs();
    log_st.delete(); log_en.delete(); log_rs.delete(); log_res.delete(); log_und.delete();
  endtask

  function automatic logic cond_ok(input logic [2:0] cd, input logic [3:0] fl);
    logic t[8];
    t[0] = fl[2];  t[1] = !fl[2];
    t[2] = fl[1];  t[3] = !fl[1];
    t[4] = fl[3];  t[5] = !fl[3];
    t[6] = (fl[3] == fl[0]);
    t[7] = 1'b1;
    return t[cd];
  endfunction

  function automatic logic [2:0] alu_of(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'b11) return 3'b111;
    case (fn[4:1])
      4'b0010, 4'b1010: return 3'b001;
      4'b0000: return 3'b010;
      4'b1100: return 3'b011;
      4'b0001: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [24:0] expect_out(input int st, input logic [1:0] op,
                                             input logic [5:0] fn, input logic und);
    logic [2:0] rs, alu;
    logic       adr, rw, mw, pcw, irw, asa, cmp;
    logic [1:0] imm, asb, res, enh;
    rs = 3'b000; alu = 3'b000; adr = 1'b0; rw = 1'b0; mw = 1'b0; pcw = 1'b0; irw = 1'b0;
    asa = 1'b0; imm = 2'b00; asb = 2'b00; res = 2'b00; enh = 2'b00;
    cmp = (op == 2'b00) && (fn[4:1] == 4'b1010);
    case (st)
      0: begin irw = 1'b1; asa = 1'b1; asb = 2'b10; res = 2'b10; pcw = 1'b1; end
      1: begin asa = 1'b1; asb = 2'b10; rs = 3'b001; end
      2: begin asb = 2'b01; imm = 2'b01; end
      3: adr = 1'b1;
      4: begin res = 2'b01; rw = 1'b1; end
      5: begin adr = 1'b1; mw = 1'b1; rs = 3'b010; end
      6, 7, 8: begin
        asb = fn[5] ? 2'b01 : 2'b00;
        alu = alu_of(op, fn);
        enh = (op == 2'b11) ? fn[2:1] : 2'b00;
        if (st == 8) rw = !cmp;
      end
      9: begin
        asb = 2'b01; imm = 2'b10; res = 2'b10; pcw = 1'b1;
`ifdef MC_BRANCH_LINK_EN
        if (fn[4]) begin rs[2] = 1'b1; rw = 1'b1; end
`else
`endif
      end
      default: ;
    endcase
    return {4'(st), rs, adr, rw, mw, pcw, irw, imm, asa, asb, alu, res, enh, und};
  endfunction

  // Runs one instruction from its FETCH cycle; abort_k asserts reset during that cycle index.
  task automatic run_instr(input logic [1:0] op, input logic [5:0] fn, input logic [2:0] cd,
                           input logic [3:0] wbflags, input int abort_k);
    int   seq[$];
    logic pass, bad;
    pass = cond_ok(cd, mflags);
    bad  = pass && (op == 2'b11) && (fn[5:4] == 2'b11);
    if (!pass || bad)        seq = '{0, 1};
    else if (op == 2'b01) begin
      if (fn[0]) seq = '{0, 1, 2, 3, 4};
      else       seq = '{0, 1, 2, 5};
    end
    else if (op == 2'b10)    seq = '{0, 1, 9};
    else if (fn[5])          seq = '{0, 1, 7, 8};
    else                     seq = '{0, 1, 6, 8};
    for (int k = 0; k < seq.size(); k++) begin
      exp_vec = expect_out(seq[k], op, fn, (k == 0) && und_pend);
      if (seq[k] == 1) begin
        Op = op; Funct = fn; Cond = cd;
      end else begin
        Op = 2'($urandom); Funct = 6'($urandom); Cond = 3'($urandom);
      end
      ALUFlags = (seq[k] == 8) ? wbflags : 4'($urandom);
      if (k == abort_k) begin
        #2;
        chk("pre-reset outputs", 32'(act_vec), 32'(exp_vec));
        reset = 1'b0;
        #1;
        chk("reset state", 32'(state), 32'd0);
        chk("reset enables", 32'({RegWrite, MemWrite, PCWrite, IRWrite}), 32'd0);
        chk("reset undef", 32'(undef), 32'd0);
        chk_en = 1'b0;
        mflags = 4'b0000;
        und_pend = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk_en = 1'b1;
        return;
      end
      @(posedge clk); #1;
      if ((seq[k] == 8) && (fn[0] || ((op == 2'b00) && (fn[4:1] == 4'b1010)))) mflags = wbflags;
    end
    und_pend = bad;
  endtask

  logic [1:0] rop;
  logic [5:0] rfn;
  logic [2:0] rcd;
  logic [3:0] rfl;
  int         rab;
  logic       lk;
  logic [3:0] t_und;

  initial begin
    #2;
    chk("reset state t0", 32'(state), 32'd0);
    chk("reset enables t0", 32'({RegWrite, MemWrite, PCWrite, IRWrite}), 32'd0);
    chk("reset undef t0", 32'(undef), 32'd0);
    @(posedge clk); #1;
    chk("reset state held", 32'(state), 32'd0);
    reset = 1'b1;
    chk_en = 1'b1;

    // LDR, always
    clear_logs();
    run_instr(2'b01, 6'b000001, 3'b111, 4'h0, -1);
    chk("ldr length", 32'(log_st.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("ldr state", 32'(log_st[i]), 32'(i));
      chk("ldr regwrite", 32'(log_en[i][3]), 32'(i == 4));
      chk("ldr resultsrc01", 32'(log_res[i] == 2'b01), 32'(i == 4));
    end

    // CMP sets Z, then BEQ is taken
    clear_logs();
    run_instr(2'b00, 6'b010101, 3'b111, 4'b0100, -1);
    chk("cmp length", 32'(log_st.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("cmp regwrite", 32'(log_en[i][3]), 32'd0);
    chk("cmp flags", 32'(dut.flags_q), 32'h4);
    clear_logs();
    run_instr(2'b10, 6'b000000, 3'b000, 4'h0, -1);
    chk("beq length", 32'(log_st.size()), 32'd3);
    chk("beq state", 32'(log_st[2]), 32'd9);
    chk("beq pcwrite", 32'(log_en[2][1]), 32'd1);

    // NE with Z=1 fails in DECODE
    clear_logs();
    run_instr(2'b00, 6'b001000, 3'b001, 4'h0, -1);
    chk("ne length", 32'(log_st.size()), 32'd2);
    chk("ne decode enables", 32'(log_en[1]), 32'd0);

    // undefined ENH, followed by a branch
    clear_logs();
    run_instr(2'b11, 6'b110000, 3'b111, 4'h0, -1);
    run_instr(2'b10, 6'b000000, 3'b111, 4'h0, -1);
    chk("undef length", 32'(log_st.size()), 32'd5);
    t_und = {log_und[0], log_und[1], log_und[2], log_und[3]};
    chk("undef pulse", 32'(t_und), 32'b0010);
    chk("undef after", 32'(log_und[4]), 32'd0);
    chk("undef next fetch", 32'(log_st[2]), 32'd0);
    for (int i = 0; i < 3; i++) chk("undef regwrite", 32'(log_en[i][3]), 32'd0);

    // branch with link bit
`ifdef MC_BRANCH_LINK_EN
    lk = 1'b1;
`else
    lk = 1'b0;
`endif
    clear_logs();
    run_instr(2'b10, 6'b010000, 3'b111, 4'h0, -1);
    chk("bl regwrite", 32'(log_en[2][3]), 32'(lk));
    chk("bl regsrc2", 32'(log_rs[2][2]), 32'(lk));

    // flags to 1111, then reset in the middle of MEMWR
    run_instr(2'b00, 6'b001001, 3'b111, 4'hf, -1);
    chk("adds flags", 32'(dut.flags_q), 32'hf);
    run_instr(2'b01, 6'b000000, 3'b111, 4'h0, 3);
    chk("flags after reset", 32'(dut.flags_q), 32'h0);
    clear_logs();
    run_instr(2'b10, 6'b000000, 3'b000, 4'h0, -1);
    chk("beq after reset length", 32'(log_st.size()), 32'd2);

    repeat (300) begin
      rop = 2'($urandom);
      rfn = 6'($urandom);
      rcd = 3'($urandom);
      rfl = 4'($urandom);
      rab = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(rop, rfn, rcd, rfl, rab);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have the following ports, listed as name, direction, width and meaning:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- Op  in  2  instruction class: 00 DP, 01 MEM, 10 BRANCH, 11 ENH.
- Funct  in  6  DP/ENH: [5]=I, [4:1]=cmd, [0]=S; MEM: [0]=L; BRANCH: [4]=link.
- Cond  in  3  condition code.
- ALUFlags  in  4  {N,Z,C,V} from the datapath ALU.
- RegSrc  out  3  [0] RA1=PC, [1] RA2=Rd, [2] write link register.
- AdrSrc  out  1  0=PC, 1=ALUOut.
- RegWrite, MemWrite, PCWrite, IRWrite  out  1 each  write enables.
- ImmSrc  out  2  00 imm8, 01 imm12, 10 imm24.
- AluSrcA  out  1  0=register A, 1=PC.
- ALUSrcB  out  2  00 reg B, 01 ExtImm, 10 increment constant.
- ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 111 ENH.
- ResultSrc  out  2  00 ALUOut, 01 read data, 10 ALU result.
- enhanced_op  out  2  sub-operation for ENH instructions.
- state  out  4  current FSM state, for debug.
- undef  out  1  one-cycle pulse on an undefined instruction.

Function
REQ-002 The FSM SHALL have the states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB and BRANCH, encoded 0..9 in that order on `state`.
REQ-003 In FETCH the outputs SHALL be IRWrite=1, AdrSrc=0, AluSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10 and PCWrite=1, and the next state SHALL be DECODE.
REQ-004 In DECODE the block SHALL drive AluSrcA=1, ALUSrcB=10, ALUControl=ADD and RegSrc[0]=1, and SHALL evaluate the condition:
- Cond 000 EQ(Z), 001 NE(!Z), 010 CS(C), 011 CC(!C), 100 MI(N), 101 PL(!N), 110 GE(N==V), 111 AL.
- The condition SHALL be evaluated against the internal flag register, not against ALUFlags.
REQ-005 If the condition fails, DECODE SHALL go to FETCH with no write enable asserted.
REQ-006 If the condition passes, DECODE SHALL select the next state as follows:
- MEM goes to MEMADR.
- BRANCH goes to BRANCH.
- DP or ENH goes to EXECI when Funct[5]=1, otherwise EXECR.
- ENH with Funct[5:4]=11 goes to FETCH, pulses undef for one cycle and asserts no enables.
REQ-007 MEMADR SHALL drive ALUSrcB=01, ImmSrc=01 and ALUControl=ADD, then go to MEMRD when Funct[0]=1, otherwise MEMWR.
REQ-008 MEMRD SHALL drive AdrSrc=1 and go to MEMWB; MEMWB SHALL drive ResultSrc=01 and RegWrite=1 and go to FETCH.
REQ-009 MEMWR SHALL drive AdrSrc=1, MemWrite=1 and RegSrc[1]=1, then go to FETCH.
REQ-010 EXECR SHALL drive ALUSrcB=00; EXECI SHALL drive ALUSrcB=01 and ImmSrc=00; both SHALL go to ALUWB.
REQ-011 The cmd decode SHALL be:
- 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 0001 EOR.
- 1010 CMP: SUB with RegWrite suppressed.
- Any other cmd: ADD.
- For ENH instructions: ALUControl=111 and enhanced_op=Funct[2:1]; enhanced_op SHALL be 00 at all other times.
REQ-012 ALUWB SHALL drive ResultSrc=00 and RegWrite=1 (except for CMP), and SHALL go to FETCH.
REQ-013 In the ALUWB cycle the flag register SHALL load ALUFlags when Funct[0]=1 or the instruction is CMP.
REQ-014 BRANCH SHALL drive ALUSrcB=01, ImmSrc=10, ALUControl=ADD, ResultSrc=10 and PCWrite=1, then go to FETCH.
REQ-015 Outputs SHALL be a function of state, latched decode inputs and the flag register only (Moore); Op, Funct and Cond SHALL be sampled once, in DECODE.
REQ-016 Latency from FETCH to the next FETCH SHALL be: LDR 5 cycles, STR 4, DP/ENH 4, B 3, condition-fail 2, undefined 2.

Reset
REQ-017 While reset=0 the block SHALL force, asynchronously, state=FETCH, flags=0000, undef=0 and all write enables (RegWrite, MemWrite, PCWrite, IRWrite) to 0.
REQ-018 Assertion of reset in any state SHALL abort the instruction with no further writes.
REQ-019 On the first rising edge of clk after reset is released, the block SHALL perform FETCH.

Configuration
REQ-020 When macro MC_BRANCH_LINK_EN is defined, BRANCH with Funct[4]=1 SHALL additionally drive RegSrc[2]=1 and RegWrite=1 so that PC+4 is written to the link register.
REQ-021 When MC_BRANCH_LINK_EN is undefined, Funct[4] SHALL be ignored and RegSrc[2] SHALL be held at 0.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Reset low mid-MEMWR -> MemWrite=0 immediately; state=0 and flags=0000.
- Op=01, Funct=000001, Cond=111 -> states 0,1,2,3,4; RegWrite=1 and ResultSrc=01 only in state 4.
- Op=00, Funct=010101 (CMP), with ALUFlags=0100 in the ALUWB cycle -> RegWrite=0 throughout; flags=0100; next B with Cond=000 reaches state 9 with PCWrite=1.
- Cond=001 with Z=1 -> DECODE returns to FETCH; no enables asserted in DECODE.
- Op=11, Funct=110000 -> undef pulses for one cycle; FETCH follows; RegWrite stays 0.
- Op=10, Funct[4]=1 with MC_BRANCH_LINK_EN -> RegSrc=1xx and RegWrite=1 in BRANCH; without the macro -> RegWrite=0.
